// File: rtl/c3540_harness_pkg.sv
// Purpose: shared sizes, MISR feedback mask and FSM state type for the c3540 response checker.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package c3540_harness_pkg;

   // c3540 has 22 primary outputs; one harness run is ten vectors
   localparam int OUT_W = 22;
   localparam int DEPTH = 10;
   localparam int IDX_W = 4;

   // MISR feedback mask, applied whenever the MSB shifts out
   localparam logic [OUT_W-1:0] MISR_POLY = 22'h200001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/c3540_resp_checker_misr_reg.sv
// Purpose: multiple-input signature register folding each accepted response into a running signature.
// Latency: sig reflects din one cycle after the en edge; clr takes priority over en.
// Backpressure: none; updates only when the parent asserts en.
module misr_reg #(
   parameter int                OUT_W     = c3540_harness_pkg::OUT_W,
   parameter logic [OUT_W-1:0]  MISR_POLY = c3540_harness_pkg::MISR_POLY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [OUT_W-1:0] din,
   output logic [OUT_W-1:0] sig
);

   logic [OUT_W-1:0] sig_next;

   // Shift left, fold the polynomial back in when the MSB leaves, then mix in the response
   always_comb begin
      sig_next = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : '0) ^ din;
   end

   // Signature register: cleared at the start of every run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= sig_next;
      end
   end

endmodule

// File: rtl/c3540_resp_checker.sv
// Purpose: compares a stream of c3540 responses against a preloaded expected table, counts mismatches, signs the stream.
// Latency: err_count/first_fail_*/signature reflect vector k one cycle after its accept; done one cycle after the last accept.
// Backpressure: resp_ready is high only while a run is in progress; resp_valid gaps of any length are tolerated.
module c3540_resp_checker
   import c3540_harness_pkg::*;
#(
   parameter int                OUT_W     = c3540_harness_pkg::OUT_W,
   parameter int                DEPTH     = c3540_harness_pkg::DEPTH,
   parameter int                IDX_W     = c3540_harness_pkg::IDX_W,
   parameter logic [OUT_W-1:0]  MISR_POLY = c3540_harness_pkg::MISR_POLY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             exp_we,
   input  logic [IDX_W-1:0] exp_addr,
   input  logic [OUT_W-1:0] exp_wdata,
   input  logic             start,
   input  logic             resp_valid,
   output logic             resp_ready,
   input  logic [OUT_W-1:0] resp_data,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [IDX_W:0]   err_count,
   output logic             first_fail_valid,
   output logic [IDX_W-1:0] first_fail_idx,
   output logic [OUT_W-1:0] signature
);

   state_t           state_q;
   state_t           state_d;
   logic [OUT_W-1:0] exp_mem [DEPTH];
   logic [IDX_W-1:0] idx_q;
   logic             run_clr;
   logic             accept;
   logic             last_vec;
   logic             mis;
   logic             tbl_we;

   // A start pulse outside RUN (re)arms the checker; inside RUN it is ignored
   assign run_clr  = start && (state_q != RUN);
   assign accept   = resp_valid && resp_ready;
   assign last_vec = (idx_q == IDX_W'(DEPTH - 1));
   // Asynchronous table read so the compare happens on the accept edge itself
   assign mis      = (resp_data != exp_mem[idx_q]);
   // Table is frozen during a run and out-of-range addresses are dropped
   assign tbl_we   = exp_we && !busy && ({1'b0, exp_addr} < (IDX_W + 1)'(DEPTH));
   assign pass     = done && (err_count == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE/DONE wait for start, RUN leaves after the last vector
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accept && last_vec) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the current state
   always_comb begin
      busy       = 1'b0;
      resp_ready = 1'b0;
      done       = 1'b0;
      case (state_q)
         RUN: begin
            busy       = 1'b1;
            resp_ready = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Expected table: retained across reset, written only while idle or done
   always_ff @(posedge clk) begin
      if (tbl_we) begin
         exp_mem[exp_addr] <= exp_wdata;
      end
   end

   // Vector index: advances on each accept, parked on the last entry at DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (run_clr) begin
         idx_q <= '0;
      end else if (accept && !last_vec) begin
         idx_q <= idx_q + 1'b1;
      end
   end

   // Mismatch count and first-failure capture; first_fail_idx latches only once per run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else if (run_clr) begin
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else if (accept && mis) begin
         err_count <= err_count + 1'b1;
         if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= idx_q;
         end
      end
   end

   misr_reg #(
      .OUT_W     (OUT_W),
      .MISR_POLY (MISR_POLY)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (run_clr),
      .en    (accept),
      .din   (resp_data),
      .sig   (signature)
   );

endmodule

// File: tb/tb_c3540_resp_checker.sv
// Purpose: directed checks of the c3540 response checker: clean/failing/gapped runs, reset abort, MISR, write/start masking.
// Latency: inputs driven and outputs sampled on the falling edge; the DUT acts on the rising edge between.
// Backpressure: responses are only offered while resp_ready is expected high.
module tb_c3540_resp_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exp_we;
   logic [3:0]  exp_addr;
   logic [21:0] exp_wdata;
   logic        start;
   logic        resp_valid;
   logic        resp_ready;
   logic [21:0] resp_data;
   logic        busy;
   logic        done;
   logic        pass;
   logic [4:0]  err_count;
   logic        first_fail_valid;
   logic [3:0]  first_fail_idx;
   logic [21:0] signature;

   int          n_vec = 0;
   int          n_err = 0;

   logic [21:0] exp_tab  [10];
   logic [21:0] resp_tab [10];

   always #5 clk = ~clk;

   c3540_resp_checker dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .exp_we           (exp_we),
      .exp_addr         (exp_addr),
      .exp_wdata        (exp_wdata),
      .start            (start),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_data        (resp_data),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .err_count        (err_count),
      .first_fail_valid (first_fail_valid),
      .first_fail_idx   (first_fail_idx),
      .signature        (signature)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [21:0] misr_f(input logic [21:0] s, input logic [21:0] d);
      return {s[20:0], 1'b0} ^ (s[21] ? 22'h200001 : 22'h000000) ^ d;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, resp_ready, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_err"}, err_count, 0);
      chk({tag, "_ffv"}, first_fail_valid, 0);
      chk({tag, "_ffi"}, first_fail_idx, 0);
      chk({tag, "_sig"}, signature, 0);
   endtask

   // Start a run, offer n responses from resp_tab with gap idle cycles before each,
   // optionally attempting a table write plus start mid-run just before vector inj.
   task automatic run_vecs(input int gap, input int n, input int inj);
      logic [21:0] msig;
      int          merr;
      bit          mffv;
      int          mffi;
      msig = '0;
      merr = 0;
      mffv = 1'b0;
      mffi = 0;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      exp_we = 1'b0;
      chk("run_busy", busy, 1);
      chk("run_clr_err", err_count, 0);
      chk("run_clr_sig", signature, 0);
      chk("run_clr_ffv", first_fail_valid, 0);
      for (int k = 0; k < n; k++) begin
         repeat (gap) begin
            resp_valid = 1'b0;
            @(negedge clk);
         end
         if (k == inj) begin
            exp_we    = 1'b1;
            exp_addr  = 4'd2;
            exp_wdata = ~exp_tab[2];
            start     = 1'b1;
            resp_valid = 1'b0;
            @(negedge clk);
            exp_we = 1'b0;
            start  = 1'b0;
            chk("inj_busy", busy, 1);
            chk("inj_err", err_count, merr);
            chk("inj_sig", signature, msig);
         end
         chk("ready", resp_ready, 1);
         chk("not_done", done, 0);
         resp_valid = 1'b1;
         resp_data  = resp_tab[k];
         @(negedge clk);
         resp_valid = 1'b0;
         if (resp_tab[k] !== exp_tab[k]) begin
            merr++;
            if (!mffv) begin
               mffv = 1'b1;
               mffi = k;
            end
         end
         msig = misr_f(msig, resp_tab[k]);
         chk("err_count", err_count, merr);
         chk("signature", signature, msig);
         chk("ff_valid", first_fail_valid, mffv);
         chk("ff_idx", first_fail_idx, mffi);
      end
      if (n == 10) begin
         chk("end_done", done, 1);
         chk("end_busy", busy, 0);
         chk("end_ready", resp_ready, 0);
         chk("end_pass", pass, (merr == 0) ? 1 : 0);
         // extra responses after completion must not be accepted
         resp_valid = 1'b1;
         resp_data  = 22'h3FFFFF;
         repeat (2) @(negedge clk);
         resp_valid = 1'b0;
         chk("hold_sig", signature, msig);
         chk("hold_err", err_count, merr);
         chk("hold_done", done, 1);
      end
   endtask

   task automatic reset_pulse(input string tag);
      #2 rst_n = 1'b0;
      #1 chk_all_zero(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      exp_we     = 1'b0;
      exp_addr   = '0;
      exp_wdata  = '0;
      start      = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      exp_tab = '{22'h0A5A5A, 22'h135791, 22'h2468AC, 22'h3FFFFF, 22'h000001,
                  22'h155555, 22'h2AAAAA, 22'h1F00F0, 22'h0C3C3C, 22'h381234};
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // load the expected table
      for (int i = 0; i < 10; i++) begin
         exp_we    = 1'b1;
         exp_addr  = 4'(i);
         exp_wdata = exp_tab[i];
         @(negedge clk);
      end
      exp_we = 1'b0;

      // T1: identical responses back-to-back
      resp_tab = exp_tab;
      run_vecs(0, 10, -1);
      chk("t1_pass", pass, 1);
      chk("t1_ffv", first_fail_valid, 0);

      // T2: flip bit 0 of vector 3 and bit 21 of vector 7
      resp_tab[3] = 22'h3FFFFE;
      resp_tab[7] = 22'h3F00F0;
      run_vecs(0, 10, -1);
      chk("t2_err", err_count, 2);
      chk("t2_ffi", first_fail_idx, 3);
      chk("t2_pass", pass, 0);

      // T3: valid only every third cycle
      resp_tab = exp_tab;
      run_vecs(2, 10, -1);
      chk("t3_pass", pass, 1);

      // T4: reset after 5 accepts (one mismatch recorded), then restart clean
      resp_tab[3] = 22'h3FFFFE;
      run_vecs(0, 5, -1);
      chk("t4_pre_err", err_count, 1);
      reset_pulse("t4_rst");
      resp_tab = exp_tab;
      run_vecs(0, 10, -1);
      chk("t4_pass", pass, 1);

      // T5a: single vector 1 from a cleared signature, then abort
      for (int i = 0; i < 10; i++) resp_tab[i] = '0;
      resp_tab[0] = 22'h000001;
      run_vecs(0, 1, -1);
      chk("t5_sig_one", signature, 22'h000001);
      reset_pulse("t5_rst");

      // T7: table write and start in the same idle cycle; first compare sees new data
      exp_tab[0] = 22'h123456;
      resp_tab   = exp_tab;
      exp_we     = 1'b1;
      exp_addr   = 4'd0;
      exp_wdata  = 22'h123456;
      run_vecs(0, 10, -1);
      chk("t7_pass", pass, 1);

      // T5b: MSB feedback path, 22'h200000 followed by nine zeros
      for (int i = 0; i < 10; i++) resp_tab[i] = '0;
      resp_tab[0] = 22'h200000;
      run_vecs(0, 10, -1);
      chk("t5_sig_poly", signature, 22'h2001FF);

      // T5c: ten zero vectors
      resp_tab[0] = '0;
      run_vecs(0, 10, -1);
      chk("t5_sig_zero", signature, 22'h000000);

      // T6: write to entry 2 and start during RUN are ignored
      resp_tab = exp_tab;
      run_vecs(0, 10, 2);
      chk("t6_pass", pass, 1);
      run_vecs(0, 10, -1);
      chk("t6_tbl_intact", pass, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
